alu_op_sequencer: RTL

//  Upstream issue stage for the floating-point ALU (add/sub/div/mul).
//  - Accepts one command (A, B, OpCode, tag) per valid/ready handshake.
//  - Holds the operands stable on the ALU inputs for SETTLE_CYCLES clocks, then captures O.
//  - Classifies the result as NaN, Inf, zero or denormal.
//  - Buffers {result, tag, flags} in a small in-order FIFO with valid/ready.
//  - Decouples producers from the ALU's registered, multi-cycle result path.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_op_sequencer_if.sv | 18 +
 rtl/alu_result_fifo.sv | 39 +++
 rtl/alu_op_sequencer.sv | 77 +++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, exponent limit, flag bit positions and sequencer FSM states
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int FLG_NAN = 3;
  localparam int FLG_INF = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_DENORM = 0;
  typedef enum logic {ST_IDLE, ST_DRIVE} state_t;
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command (cmd_valid/ready, a, b, op, tag) and result (res_valid/ready, data, tag, flags) handshakes; master=producer/consumer, slave=sequencer
interface alu_op_sequencer_if #(parameter int TAG_W = 4);
  logic cmd_valid;
  logic cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0] cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic res_valid;
  logic res_ready;
  logic [31:0] res_data;
  logic [TAG_W-1:0] res_tag;
  logic [3:0] res_flags;
  modport master(output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, res_ready,
                 input cmd_ready, res_valid, res_data, res_tag, res_flags);
  modport slave(input cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, res_ready,
                output cmd_ready, res_valid, res_data, res_tag, res_flags);
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: in-order W-bit FIFO of DEPTH entries; ports clk, rst, push/din, pop/dout, full, empty, count
module alu_result_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = int'(count) == DEPTH;
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      count <= count + NW'(do_push) - NW'(do_pop);
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: holds a command on alu_a/b/op for SETTLE_CYCLES clocks, captures alu_o with its tag and {nan,inf,zero,denorm} flags into a result FIFO; ports clk, rst, bus (slave), alu_a/b/op out, alu_o in, busy
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic rst,
  alu_op_sequencer_if.slave bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [31:0] alu_o,
  output logic busy
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int W = 32 + TAG_W + 4;
  localparam int NW = $clog2(FIFO_DEPTH+1);
  function automatic logic [3:0] classify(input logic [31:0] o);
    logic [3:0] f;
    f = '0;
    f[FLG_NAN] = o[30:23] == EXP_MAX && o[22:0] != '0;
    f[FLG_INF] = o[30:23] == EXP_MAX && o[22:0] == '0;
    f[FLG_ZERO] = o[30:23] == '0 && o[22:0] == '0;
    f[FLG_DENORM] = o[30:23] == '0 && o[22:0] != '0;
    return f;
  endfunction
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [TAG_W-1:0] tag;
  logic accept, push, full, empty;
  logic [NW-1:0] count;
  logic [W-1:0] head;
  always_comb begin
    bus.cmd_ready = state == ST_IDLE && !full;
    accept = bus.cmd_valid && bus.cmd_ready;
    push = state == ST_DRIVE && cnt == '0;
    state_nxt = accept ? ST_DRIVE : push ? ST_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      tag <= '0;
      cnt <= '0;
    end else if (accept) begin
      alu_a <= bus.cmd_a;
      alu_b <= bus.cmd_b;
      alu_op <= bus.cmd_op;
      tag <= bus.cmd_tag;
      cnt <= CW'(SETTLE_CYCLES - 1);
    end else if (state == ST_DRIVE && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end
  alu_result_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({alu_o, tag, classify(alu_o)}),
    .pop(bus.res_ready),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign {bus.res_data, bus.res_tag, bus.res_flags} = head;
  assign bus.res_valid = !empty;
  assign busy = state != ST_IDLE || count != '0;
endmodule
